// File: rtl/cook_sequencer.sv
// Microwave front-panel sequencer: keypad debounce and M:ST:SO entry, start/stop
// edge detection, cook/pause/done control of the countdown timer datapath.
module cook_sequencer #(
   parameter int DEBOUNCE    = 3,
   parameter int TICK_DIV    = 100,
   parameter int BEEP_CYCLES = 200
) (
   input  logic       clock,
   input  logic       clearn,
   input  logic [9:0] keypad,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic       load,
   output logic [3:0] load_mins,
   output logic [3:0] load_tens,
   output logic [3:0] load_ones,
   output logic       dec_en,
   output logic       mag_on,
   output logic       done_beep,
   output logic [2:0] state
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ENTRY   = 3'd1;
   localparam logic [2:0] COOKING = 3'd2;
   localparam logic [2:0] PAUSED  = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

   logic [9:0]    key_reg;
   logic [3:0]    stable_reg, stable_next;
   logic          armed_reg;
   logic          key_valid, key_accept;
   logic [3:0]    key_digit;

   logic          startn_reg, startn_dly_reg, stopn_reg, stopn_dly_reg;
   logic          start_ev, stop_ev;

   logic [2:0]    state_reg, state_next;
   logic [3:0]    mins_reg, mins_next, tens_reg, tens_next, ones_reg, ones_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic [BW-1:0] beep_cnt_reg, beep_cnt_next;
   logic          first_reg, first_next;
   logic          load_reg, load_next;
   logic          mag_on_reg, beep_reg;
   logic          wrap, buf_nonzero, start_ok;

   assign key_valid = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);

   always_comb begin
      key_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (keypad[i]) key_digit = 4'(i);
      end
   end

   // Run length of the current one-hot code, saturating; multi-hot or idle restarts it.
   always_comb begin
      stable_next = 4'd0;
      if (key_valid) begin
         if (keypad == key_reg)
            stable_next = (stable_reg == 4'd15) ? 4'd15 : stable_reg + 4'd1;
         else
            stable_next = 4'd1;
      end
   end

   assign key_accept = armed_reg && key_valid && (stable_next == 4'(DEBOUNCE));

   always_ff @(posedge clock) begin
      if (!clearn) begin
         key_reg    <= 10'd0;
         stable_reg <= 4'd0;
         armed_reg  <= 1'b1;
      end else begin
         key_reg    <= keypad;
         stable_reg <= stable_next;
         if (keypad == 10'd0)
            armed_reg <= 1'b1;
         else if (key_accept)
            armed_reg <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!clearn) begin
         startn_reg     <= 1'b1;
         startn_dly_reg <= 1'b1;
         stopn_reg      <= 1'b1;
         stopn_dly_reg  <= 1'b1;
      end else begin
         startn_reg     <= startn;
         startn_dly_reg <= startn_reg;
         stopn_reg      <= stopn;
         stopn_dly_reg  <= stopn_reg;
      end
   end

   assign start_ev    = startn_dly_reg & ~startn_reg;
   assign stop_ev     = stopn_dly_reg & ~stopn_reg;
   assign wrap        = (presc_reg == PW'(TICK_DIV - 1));
   assign buf_nonzero = ({mins_reg, tens_reg, ones_reg} != 12'd0);
   assign start_ok    = start_ev && door_closed && buf_nonzero && (tens_reg <= 4'd5);

   always_comb begin
      state_next    = state_reg;
      mins_next     = mins_reg;
      tens_next     = tens_reg;
      ones_next     = ones_reg;
      presc_next    = presc_reg;
      beep_cnt_next = beep_cnt_reg;
      first_next    = first_reg;
      load_next     = 1'b0;
      dec_en        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (key_accept) begin
               state_next = ENTRY;
               mins_next  = 4'd0;
               tens_next  = 4'd0;
               ones_next  = key_digit;
            end
         end
         ENTRY: begin
            if (stop_ev) begin
               state_next = IDLE;
               mins_next  = 4'd0;
               tens_next  = 4'd0;
               ones_next  = 4'd0;
            end else if (start_ok) begin
               state_next = COOKING;
               load_next  = 1'b1;
               presc_next = '0;
               first_next = 1'b1;
            end else if (key_accept) begin
               mins_next = tens_reg;
               tens_next = ones_reg;
               ones_next = key_digit;
            end
         end
         COOKING: begin
            first_next = 1'b0;
            // The timer only sees the load one cycle later, so its zero flag is stale here.
            if (timer_zero && !first_reg) begin
               state_next    = DONE;
               beep_cnt_next = '0;
            end else if (stop_ev || !door_closed) begin
               state_next = PAUSED;
            end else begin
               presc_next = wrap ? '0 : presc_reg + PW'(1);
               dec_en     = wrap;
            end
         end
         PAUSED: begin
            if (stop_ev) begin
               state_next = IDLE;
               load_next  = 1'b1;
               mins_next  = 4'd0;
               tens_next  = 4'd0;
               ones_next  = 4'd0;
            end else if (start_ev && door_closed && !timer_zero) begin
               state_next = COOKING;
            end
         end
         DONE: begin
            if (key_accept) begin
               state_next = ENTRY;
               mins_next  = 4'd0;
               tens_next  = 4'd0;
               ones_next  = key_digit;
            end else if (!door_closed || stop_ev || (beep_cnt_reg == BW'(BEEP_CYCLES - 1))) begin
               state_next = IDLE;
               mins_next  = 4'd0;
               tens_next  = 4'd0;
               ones_next  = 4'd0;
            end else begin
               beep_cnt_next = beep_cnt_reg + BW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clearn) begin
         state_reg    <= IDLE;
         mins_reg     <= 4'd0;
         tens_reg     <= 4'd0;
         ones_reg     <= 4'd0;
         presc_reg    <= '0;
         beep_cnt_reg <= '0;
         first_reg    <= 1'b0;
         load_reg     <= 1'b0;
         mag_on_reg   <= 1'b0;
         beep_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         mins_reg     <= mins_next;
         tens_reg     <= tens_next;
         ones_reg     <= ones_next;
         presc_reg    <= presc_next;
         beep_cnt_reg <= beep_cnt_next;
         first_reg    <= first_next;
         load_reg     <= load_next;
         mag_on_reg   <= (state_next == COOKING);
         beep_reg     <= (state_next == DONE);
      end
   end

   // The cancel load clears the buffer on the same edge, so the load value is 0:00.
   assign load      = load_reg;
   assign load_mins = mins_reg;
   assign load_tens = tens_reg;
   assign load_ones = ones_reg;
   assign mag_on    = mag_on_reg;
   assign done_beep = beep_reg;
   assign state     = state_reg;

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer with a behavioural seconds-counter timer model.
module tb_cook_sequencer;

   logic       clock = 1'b0;
   logic       clearn;
   logic [9:0] keypad;
   logic       startn, stopn, door_closed, timer_zero;
   logic       load, dec_en, mag_on, done_beep;
   logic [3:0] load_mins, load_tens, load_ones;
   logic [2:0] state;

   int tests = 0;
   int fails = 0;
   int secs  = 0;
   int pulses;

   cook_sequencer #(.DEBOUNCE(3), .TICK_DIV(4), .BEEP_CYCLES(20)) dut (
      .clock(clock), .clearn(clearn), .keypad(keypad), .startn(startn), .stopn(stopn),
      .door_closed(door_closed), .timer_zero(timer_zero), .load(load),
      .load_mins(load_mins), .load_tens(load_tens), .load_ones(load_ones),
      .dec_en(dec_en), .mag_on(mag_on), .done_beep(done_beep), .state(state)
   );

   always #5 clock = ~clock;

   // Timer datapath stand-in: whole seconds, zero flag combinational.
   always @(posedge clock) begin
      if (load)
         secs <= int'(load_mins) * 60 + int'(load_tens) * 10 + int'(load_ones);
      else if (dec_en && secs > 0)
         secs <= secs - 1;
   end
   assign timer_zero = (secs == 0);

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input int digit, input int hold);
      keypad = 10'd1 << digit;
      step(hold);
      keypad = 10'd0;
      step(1);
   endtask

   task automatic pulse_start();
      startn = 1'b0;
      step(1);
      startn = 1'b1;
      step(1);
   endtask

   task automatic pulse_stop();
      stopn = 1'b0;
      step(1);
      stopn = 1'b1;
      step(1);
   endtask

   initial begin
      clearn = 1'b0; keypad = 10'd0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
      step(2);
      check("rst_state", 16'(state), 16'd0);
      check("rst_outs", {11'd0, load, dec_en, mag_on, done_beep, 1'b0}, 16'd0);
      check("rst_buf", {4'd0, load_mins, load_tens, load_ones}, 16'h000);
      clearn = 1'b1;
      step(1);

      // Key entry 1,3,5
      press(1, 10);
      check("key1_state", 16'(state), 16'd1);
      check("key1_buf", {4'd0, load_mins, load_tens, load_ones}, 16'h001);
      press(3, 10);
      check("key3_buf", {4'd0, load_mins, load_tens, load_ones}, 16'h013);
      press(5, 10);
      check("key5_buf", {4'd0, load_mins, load_tens, load_ones}, 16'h135);

      // Glitch and multi-hot codes must not shift
      press(7, 2);
      check("glitch_buf", {4'd0, load_mins, load_tens, load_ones}, 16'h135);
      keypad = 10'b0000000110;
      step(10);
      keypad = 10'd0;
      step(1);
      check("multihot_buf", {4'd0, load_mins, load_tens, load_ones}, 16'h135);

      // Start with door open is ignored
      door_closed = 1'b0;
      pulse_start();
      check("door_open_start_state", 16'(state), 16'd1);
      check("door_open_start_load", 16'(load), 16'd0);
      door_closed = 1'b1;
      step(1);

      // Stop in ENTRY clears the buffer
      pulse_stop();
      check("entry_stop_state", 16'(state), 16'd0);
      check("entry_stop_buf", {4'd0, load_mins, load_tens, load_ones}, 16'h000);

      // 0:75 rejected
      press(7, 5);
      press(5, 5);
      check("buf_075", {4'd0, load_mins, load_tens, load_ones}, 16'h075);
      pulse_start();
      check("start_075_state", 16'(state), 16'd1);
      check("start_075_load", 16'(load), 16'd0);

      // 0:00 rejected
      pulse_stop();
      press(0, 5);
      check("zero_entry_state", 16'(state), 16'd1);
      pulse_start();
      check("start_000_state", 16'(state), 16'd1);
      check("start_000_load", 16'(load), 16'd0);

      // 0:02 full cook
      press(2, 5);
      check("buf_002", {4'd0, load_mins, load_tens, load_ones}, 16'h002);
      pulse_start();
      check("c0_load", 16'(load), 16'd1);
      check("c0_state", 16'(state), 16'd2);
      check("c0_load_val", {4'd0, load_mins, load_tens, load_ones}, 16'h002);
      step(1);
      check("c1_load", 16'(load), 16'd0);
      check("c1_mag", 16'(mag_on), 16'd1);
      step(1);
      check("c2_dec", 16'(dec_en), 16'd0);
      step(1);
      check("c3_dec", 16'(dec_en), 16'd1);
      step(4);
      check("c7_dec", 16'(dec_en), 16'd1);
      step(1);
      check("c8_state", 16'(state), 16'd2);
      check("c8_dec", 16'(dec_en), 16'd0);
      step(1);
      check("done_state", 16'(state), 16'd4);
      check("done_beep", 16'(done_beep), 16'd1);
      check("done_mag", 16'(mag_on), 16'd0);
      step(19);
      check("beep_last_state", 16'(state), 16'd4);
      check("beep_last", 16'(done_beep), 16'd1);
      step(1);
      check("beep_end_state", 16'(state), 16'd0);
      check("beep_end_beep", 16'(done_beep), 16'd0);
      check("beep_end_buf", {4'd0, load_mins, load_tens, load_ones}, 16'h000);

      // Door-open pause at a wrap cycle, then resume
      press(9, 5);
      pulse_start();
      check("p_c0_load", 16'(load), 16'd1);
      step(7);
      check("p_c7_dec_pre", 16'(dec_en), 16'd1);
      door_closed = 1'b0;
      #1;
      check("p_c7_dec_suppressed", 16'(dec_en), 16'd0);
      step(1);
      check("paused_state", 16'(state), 16'd3);
      check("paused_mag", 16'(mag_on), 16'd0);
      pulses = int'(dec_en);
      repeat (19) begin
         step(1);
         pulses += int'(dec_en);
      end
      check("paused_no_dec", 16'(pulses), 16'd0);
      door_closed = 1'b1;
      pulse_start();
      check("resume_state", 16'(state), 16'd2);
      check("resume_load", 16'(load), 16'd0);
      check("resume_dec", 16'(dec_en), 16'd1);
      check("resume_mag", 16'(mag_on), 16'd1);
      step(1);
      check("resume_r1_dec", 16'(dec_en), 16'd0);

      // Stop to pause, stop again to cancel
      pulse_stop();
      check("stop_pause_state", 16'(state), 16'd3);
      pulse_stop();
      check("cancel_state", 16'(state), 16'd0);
      check("cancel_load", 16'(load), 16'd1);
      check("cancel_val", {4'd0, load_mins, load_tens, load_ones}, 16'h000);
      step(1);
      check("cancel_load_end", 16'(load), 16'd0);

      // Reset during cook
      press(3, 5);
      pulse_start();
      step(2);
      check("pre_rst_mag", 16'(mag_on), 16'd1);
      clearn = 1'b0;
      step(1);
      check("mid_rst_state", 16'(state), 16'd0);
      check("mid_rst_outs", {11'd0, load, dec_en, mag_on, done_beep, 1'b0}, 16'd0);
      check("mid_rst_buf", {4'd0, load_mins, load_tens, load_ones}, 16'h000);
      clearn = 1'b1;
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
- Control FSM sitting between the front-panel inputs (keypad, start/stop, door) and the countdown timer datapath of the microwave.
- Debounces the one-hot keypad and assembles an M:ST:SO entry buffer.
- Loads the timer, issues one decrement strobe per second while cooking, and drives mag_on and an end-of-cook beep.
- Handles pause/resume/cancel and door interlock.

Parameters:
- DEBOUNCE, 3: cycles a one-hot keypad code must be stable before acceptance (1..15).
- TICK_DIV, 100: clock cycles per 1 s decrement strobe (100 Hz panel clock).
- BEEP_CYCLES, 200: cycles done_beep stays high after cook completes.

Ports:
- clock, input, 1: system clock, rising edge.
- clearn, input, 1: reset.
- keypad, input, 10: one-hot digit keys, bit i = digit i; all-zero = no key.
- startn, input, 1: start button, active-low.
- stopn, input, 1: stop/cancel button, active-low.
- door_closed, input, 1: 1 = door closed.
- timer_zero, input, 1: from timer, 1 when all timer digits are 0.
- load, output, 1: one-cycle strobe; timer loads load_mins/load_tens/load_ones.
- load_mins, output, 4: BCD minutes to load.
- load_tens, output, 4: BCD seconds-tens to load.
- load_ones, output, 4: BCD seconds-ones to load.
- dec_en, output, 1: one-cycle strobe; timer decrements by 1 s.
- mag_on, output, 1: magnetron enable.
- done_beep, output, 1: end-of-cook indicator.
- state, output, 3: FSM state (IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4).

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (clearn=0 at a rising edge):
  - state=IDLE; buffer=0:00; prescaler=0; debounce cleared and armed; start/stop edge registers=1.
  - All outputs 0.
  - Reset overrides all other inputs, including mid-cook, mid-load and mid-beep.
- Key capture:
  - Code valid only if exactly one bit is set; multi-hot codes reset the stability counter and are ignored.
  - Accept when the same valid code is held DEBOUNCE consecutive cycles. Exactly one acceptance per press.
  - Re-arm only after keypad==0 for at least 1 cycle.
  - On acceptance: mins<=tens, tens<=ones, ones<=digit. Example: entry 1,3,5 gives 1:35.
  - Keys are ignored in COOKING and PAUSED (debounce still runs, but nothing is shifted).
- Start/stop: falling-edge detect on registered startn/stopn; one event per press.
- IDLE:
  - Accepted key -> ENTRY, with the digit shifted into a zeroed buffer.
  - Start ignored.
- ENTRY, start event accepted only if all of:
  - door_closed=1;
  - buffer != 0:00;
  - load_tens <= 5.
  - Then load=1 for one cycle and state -> COOKING on the same edge. Prescaler cleared.
  - Otherwise start is ignored.
  - Stop event: buffer <- 0:00, state -> IDLE.
- COOKING:
  - mag_on=1 (registered; high exactly while state==COOKING).
  - Prescaler counts 0..TICK_DIV-1; dec_en=1 in the cycle it wraps.
  - timer_zero is ignored in the first COOKING cycle after load, to cover timer latency.
  - Exit priority, highest first:
    1. timer_zero=1 -> DONE, done_beep=1.
    2. Stop event or door_closed=0 -> PAUSED; prescaler holds its value.
  - dec_en is suppressed in any exit cycle.
- PAUSED:
  - mag_on=0.
  - Start with door_closed=1 and timer_zero=0 -> COOKING. No load; prescaler resumes from its held value.
  - Stop event -> IDLE, issuing load=1 with 0:00 (clears the timer) and buffer <- 0:00.
- DONE:
  - done_beep=1 for BEEP_CYCLES, then -> IDLE, buffer 0:00.
  - Accepted key aborts the beep -> ENTRY with a fresh buffer.
  - Door open or stop event aborts the beep -> IDLE.
- Simultaneous events:
  - Start and stop in the same cycle: stop wins.
  - Start with door open: ignored in every state.
- load_* outputs continuously reflect the buffer, except during a cancel load, when they are 0.

Test Plan:
- (DEBOUNCE=3, TICK_DIV=4) keys 1,3,5 each held 10 cycles, 0 for 1 cycle between -> state=ENTRY, load_mins/tens/ones=1/3/5; each press shifts once.
- Glitch 2-cycle key and multi-hot 0b0000000110 -> no shift; buffer unchanged.
- Buffer 0:02, startn pulse low with door closed -> load=1 for one cycle, mag_on=1 next cycle, dec_en every 4 cycles. Model timer hits zero -> DONE, mag_on=0, done_beep high BEEP_CYCLES, then IDLE.
- COOKING, door_closed=0 for 20 cycles -> PAUSED, mag_on=0, no dec_en. Close door and start -> COOKING, no load, first dec_en lands at the held prescaler remainder.
- Buffer 0:75 + start -> rejected, state stays ENTRY. Buffer 0:00 + start -> rejected. Start with door open -> rejected.
- clearn=0 mid-COOKING -> next edge: all outputs 0, state=IDLE. Separately: PAUSED + stop -> load=1 with 0:00, state=IDLE.
